// File: rtl/load_store_unit_pkg.sv
// Shared load/store opcodes, FSM states and access-size decode for the load/store unit.
package load_store_unit_pkg;

  localparam logic [5:0] ALU_LB  = 6'h20;
  localparam logic [5:0] ALU_LH  = 6'h21;
  localparam logic [5:0] ALU_LW  = 6'h22;
  localparam logic [5:0] ALU_LBU = 6'h23;
  localparam logic [5:0] ALU_LHU = 6'h24;
  localparam logic [5:0] ALU_SB  = 6'h28;
  localparam logic [5:0] ALU_SH  = 6'h29;
  localparam logic [5:0] ALU_SW  = 6'h2a;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } lsu_state_e;

  typedef enum logic [1:0] {
    SIZE_B,
    SIZE_H,
    SIZE_W
  } access_size_e;

  // Unknown codes fall back to word size so they still get an alignment check.
  function automatic access_size_e access_size(input logic [5:0] code);
    case (code)
      ALU_LB, ALU_LBU, ALU_SB: access_size = SIZE_B;
      ALU_LH, ALU_LHU, ALU_SH: access_size = SIZE_H;
      default:                 access_size = SIZE_W;
    endcase
  endfunction

  function automatic logic zero_extend(input logic [5:0] code);
    return (code == ALU_LBU) || (code == ALU_LHU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables and replicated store data, misalignment
// detection, and load byte/half extraction with sign or zero extension. No state.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [5:0]  alucode,
  input  logic        store,
  input  logic [1:0]  ea_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misalign,
  output logic [31:0] load_data
);

  access_size_e size;
  logic         uns;
  logic [7:0]   byte_val;
  logic [15:0]  half_val;

  always_comb begin
    size      = access_size(alucode);
    uns       = zero_extend(alucode);
    byte_val  = rdata[{ea_lo, 3'b000} +: 8];
    half_val  = rdata[{ea_lo[1], 4'b0000} +: 16];
    be        = 4'b1111;
    wdata     = store_data;
    misalign  = 1'b0;
    load_data = rdata;
    case (size)
      SIZE_B: begin
        if (store) be = 4'b0001 << ea_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = uns ? {24'b0, byte_val} : {{24{byte_val[7]}}, byte_val};
      end
      SIZE_H: begin
        if (store) be = 4'b0011 << ea_lo;
        wdata     = {2{store_data[15:0]}};
        misalign  = ea_lo[0];
        load_data = uns ? {16'b0, half_val} : {{16{half_val[15]}}, half_val};
      end
      default: begin
        misalign  = |ea_lo;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store stage: one access per handshake over req/gnt/rvalid; latency 3 load, 2 store, 1 misaligned/no-op.
// Backpressure: req_ready only in IDLE; dmem_req held until gnt; resp_* held until resp_ready.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  alucode,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [31:0] base,
  input  logic [31:0] offset,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_addr,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        resp_wren,
  output logic        misalign,
  output logic        bus_err
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  lsu_state_e    state, state_next;
  logic [5:0]    code_q;
  logic [1:0]    ea_lo_q;
  logic          store_q;
  logic [TW-1:0] timer;

  logic [31:0] ea_in;
  logic        accept, is_mem, store_in, timed_out;
  logic [5:0]  code_sel;
  logic [1:0]  ea_lo_sel;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, load_data_c;
  logic        mis_c;

  assign ea_in     = base + offset;
  assign accept    = req_valid && (state == ST_IDLE);
  assign is_mem    = is_load || is_store;
  assign store_in  = is_store && !is_load;
  // timer holds the number of REQ/WAIT cycles already spent, so this is the last allowed one
  assign timed_out = (timer == TIMEOUT_LAST);

  // In IDLE the aligner decodes the incoming request; afterwards it extracts load data.
  assign code_sel  = (state == ST_IDLE) ? alucode     : code_q;
  assign ea_lo_sel = (state == ST_IDLE) ? ea_in[1:0]  : ea_lo_q;

  lsu_align u_align (
    .alucode    (code_sel),
    .store      (store_in),
    .ea_lo      (ea_lo_sel),
    .store_data (store_data),
    .rdata      (dmem_rdata),
    .be         (be_c),
    .wdata      (wdata_c),
    .misalign   (mis_c),
    .load_data  (load_data_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (req_valid) state_next = (is_mem && !mis_c) ? ST_REQ : ST_RESP;
      ST_REQ: begin
        if (dmem_gnt)       state_next = store_q ? ST_RESP : ST_WAIT;
        else if (timed_out) state_next = ST_RESP;
      end
      ST_WAIT: if (dmem_rvalid || timed_out) state_next = ST_RESP;
      ST_RESP: if (resp_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready  <= 1'b1;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_rd    <= '0;
      resp_wren  <= 1'b0;
      misalign   <= 1'b0;
      bus_err    <= 1'b0;
      code_q     <= '0;
      ea_lo_q    <= '0;
      store_q    <= 1'b0;
      timer      <= '0;
    end else begin
      req_ready  <= (state_next == ST_IDLE);
      dmem_req   <= (state_next == ST_REQ);
      resp_valid <= (state_next == ST_RESP);

      if (accept) begin
        code_q    <= alucode;
        ea_lo_q   <= ea_in[1:0];
        store_q   <= store_in;
        resp_rd   <= rd_addr;
        timer     <= '0;
        misalign  <= is_mem && mis_c;
        bus_err   <= 1'b0;
        resp_wren <= 1'b0;
        resp_data <= '0;
      end

      if (accept && (state_next == ST_REQ)) begin
        dmem_addr  <= {ea_in[31:2], 2'b00};
        dmem_we    <= store_in;
        dmem_be    <= be_c;
        dmem_wdata <= wdata_c;
      end else if (state_next != ST_REQ) begin
        dmem_addr  <= '0;
        dmem_we    <= 1'b0;
        dmem_be    <= '0;
        dmem_wdata <= '0;
      end

      if ((state == ST_REQ) || (state == ST_WAIT)) timer <= timer + 1'b1;

      if (state == ST_WAIT && dmem_rvalid) begin
        resp_data <= load_data_c;
        resp_wren <= 1'b1;
      end else if (((state == ST_REQ && !dmem_gnt) || (state == ST_WAIT)) && timed_out) begin
        bus_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit: a spec-level reference model and a per-cycle compare process,
// plus directed accesses pinned to hand-computed values.
`timescale 1ns/1ps
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid, req_ready, is_load, is_store;
  logic [5:0]  alucode;
  logic [31:0] base, offset, store_data;
  logic [4:0]  rd_addr;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        resp_valid, resp_ready, resp_wren, misalign, bus_err;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .alucode(alucode),
    .is_load(is_load), .is_store(is_store), .base(base), .offset(offset), .store_data(store_data),
    .rd_addr(rd_addr), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_rd(resp_rd), .resp_wren(resp_wren), .misalign(misalign), .bus_err(bus_err)
  );

  typedef struct {
    logic [5:0]  code;
    logic        ld, st;
    logic [31:0] base, off, sd, rdata;
    logic [4:0]  rd;
    int          gnt_dly, rv_dly, rdy_dly;
    bit          no_gnt, no_rv;
  } txn_t;

  typedef struct {
    bit          mem, store, mis, berr, wren, we;
    logic [31:0] addr, wdata, data;
    logic [3:0]  be;
    logic [4:0]  rd;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   phase  = 0;   // 0 idle, 1 request outstanding, 2 awaiting read data, 3 response pending
  bit   chk_en = 0;
  exp_t exp_cur;
  logic [5:0] codes [8];

  bit          obs_seen_req, obs_seen_resp;
  int          obs_lat, obs_req_cycles;
  logic [31:0] obs_addr, obs_wdata, obs_data;
  logic [3:0]  obs_be;
  logic        obs_we, obs_wren, obs_mis, obs_berr;
  logic [4:0]  obs_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input txn_t t);
    exp_t m;
    logic [31:0] ea, v;
    int sz, lane;
    bit uns;
    ea   = t.base + t.off;
    lane = int'(ea[1:0]);
    case (t.code)
      ALU_LB, ALU_LBU, ALU_SB: sz = 1;
      ALU_LH, ALU_LHU, ALU_SH: sz = 2;
      default:                 sz = 4;
    endcase
    uns     = (t.code == ALU_LBU) || (t.code == ALU_LHU);
    m.rd    = t.rd;
    m.mis   = (t.ld || t.st) && (lane % sz != 0);
    m.mem   = (t.ld || t.st) && !m.mis;
    m.store = t.st && !t.ld;
    m.we    = m.store;
    m.addr  = ea - 32'(lane);
    m.be    = 4'hf;
    m.wdata = t.sd;
    if (m.store && sz == 1) begin
      m.be = 4'(1 << lane); m.wdata = (t.sd & 32'hff) * 32'h01010101;
    end
    if (m.store && sz == 2) begin
      m.be = 4'(3 << lane); m.wdata = (t.sd & 32'hffff) * 32'h00010001;
    end
    m.berr = m.mem && (t.no_gnt || (!m.store && t.no_rv));
    m.wren = m.mem && !m.store && !m.berr;
    v = t.rdata >> (8 * lane);
    if (sz == 1) begin
      v = v & 32'hff;
      if (!uns && v >= 32'd128) v = v - 32'd256;
    end else if (sz == 2) begin
      v = v & 32'hffff;
      if (!uns && v >= 32'd32768) v = v - 32'd65536;
    end
    m.data = m.wren ? v : 32'h0;
    return m;
  endfunction

  function automatic txn_t mk(input logic [5:0] code, input logic ld, input logic st,
                              input logic [31:0] b, input logic [31:0] o, input logic [31:0] sd,
                              input logic [4:0] rd, input logic [31:0] rdata, input int gd,
                              input int rvd, input int rdd, input bit nog, input bit norv);
    txn_t t;
    t.code = code; t.ld = ld; t.st = st; t.base = b; t.off = o; t.sd = sd; t.rd = rd;
    t.rdata = rdata; t.gnt_dly = gd; t.rv_dly = rvd; t.rdy_dly = rdd; t.no_gnt = nog; t.no_rv = norv;
    return t;
  endfunction

  // Compare process: every cycle after reset, DUT outputs against the model's expectation.
  initial begin
    wait (chk_en);
    forever begin
      @(negedge clk);
      check("req_ready", req_ready, phase == 0);
      check("dmem_req", dmem_req, phase == 1);
      check("resp_valid", resp_valid, phase == 3);
      if (phase == 1) begin
        check("dmem_addr", dmem_addr, exp_cur.addr);
        check("dmem_be", dmem_be, exp_cur.be);
        check("dmem_we", dmem_we, exp_cur.we);
        if (exp_cur.store) check("dmem_wdata", dmem_wdata, exp_cur.wdata);
      end
      if (phase == 3) begin
        check("resp_data", resp_data, exp_cur.data);
        check("resp_rd", resp_rd, exp_cur.rd);
        check("resp_wren", resp_wren, exp_cur.wren);
        check("misalign", misalign, exp_cur.mis);
        check("bus_err", bus_err, exp_cur.berr);
      end
    end
  end

  task automatic run_txn(input txn_t t);
    int  ncyc, wcyc, rcyc, lat;
    bit  done;
    exp_cur = model(t);
    obs_seen_req = 0; obs_seen_resp = 0; obs_req_cycles = 0;
    @(negedge clk);
    req_valid = 1; alucode = t.code; is_load = t.ld; is_store = t.st; base = t.base;
    offset = t.off; store_data = t.sd; rd_addr = t.rd;
    dmem_gnt = 0; dmem_rvalid = 0; resp_ready = 0;
    @(posedge clk);
    phase = exp_cur.mem ? 1 : 3;
    lat = 1; ncyc = 0; wcyc = 0; rcyc = 0; done = 0;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      req_valid = 0; base = $urandom; offset = $urandom; store_data = $urandom;
      rd_addr = 5'($urandom); alucode = 6'($urandom);
      dmem_gnt = 0; dmem_rvalid = 0; resp_ready = 0; dmem_rdata = $urandom;
      if (dmem_req) begin
        obs_req_cycles++;
        if (!obs_seen_req) begin
          obs_addr = dmem_addr; obs_be = dmem_be; obs_wdata = dmem_wdata; obs_we = dmem_we;
          obs_seen_req = 1;
        end
      end
      if (resp_valid && !obs_seen_resp) begin
        obs_lat = lat; obs_data = resp_data; obs_wren = resp_wren; obs_mis = misalign;
        obs_berr = bus_err; obs_rd = resp_rd; obs_seen_resp = 1;
      end
      case (phase)
        1: if (!t.no_gnt && ncyc == t.gnt_dly) begin
             dmem_gnt = 1; dmem_rvalid = 1'($urandom);
           end
        2: if (!t.no_rv && wcyc == t.rv_dly - 1) begin
             dmem_rvalid = 1; dmem_rdata = t.rdata;
           end
        3: if (rcyc == t.rdy_dly) resp_ready = 1;
        default: ;
      endcase
      @(posedge clk);
      lat++;
      case (phase)
        1: begin
          ncyc++;
          if (dmem_gnt) phase = exp_cur.store ? 3 : 2;
          else if (ncyc == TO) phase = 3;
        end
        2: begin
          ncyc++; wcyc++;
          if (dmem_rvalid || ncyc == TO) phase = 3;
        end
        3: begin
          rcyc++;
          if (resp_ready) begin phase = 0; done = 1; end
        end
        default: ;
      endcase
    end
    check("txn_completed", 32'(done), 32'd1);
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req_valid = 0; dmem_gnt = 1'($urandom); dmem_rvalid = 1'($urandom);
      dmem_rdata = $urandom; resp_ready = 1'($urandom);
    end
    @(negedge clk);
    dmem_gnt = 0; dmem_rvalid = 0; resp_ready = 0;
  endtask

  task automatic reset_in_wait();
    txn_t t;
    t = mk(ALU_LW, 1, 0, 32'h200, 0, 0, 5'd7, 0, 0, 1, 0, 0, 1);
    exp_cur = model(t);
    @(negedge clk);
    req_valid = 1; alucode = t.code; is_load = 1; is_store = 0; base = t.base; offset = 0; rd_addr = t.rd;
    @(posedge clk); phase = 1;
    @(negedge clk); req_valid = 0; dmem_gnt = 1;
    @(posedge clk); phase = 2;
    @(negedge clk); dmem_gnt = 0;
    @(posedge clk);
    @(negedge clk); rst = 1;
    @(posedge clk); phase = 0;
    @(negedge clk); rst = 0; dmem_rvalid = 1; dmem_rdata = $urandom;
    @(negedge clk); dmem_rvalid = 0;
    repeat (3) @(negedge clk);
    check("rst_no_resp", resp_valid, 1'b0);
    check("rst_ready", req_ready, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    codes[0] = ALU_LB; codes[1] = ALU_LH; codes[2] = ALU_LW; codes[3] = ALU_LBU;
    codes[4] = ALU_LHU; codes[5] = ALU_SB; codes[6] = ALU_SH; codes[7] = ALU_SW;
    req_valid = 0; alucode = 0; is_load = 0; is_store = 0; base = 0; offset = 0;
    store_data = 0; rd_addr = 0; dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0; resp_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_dmem_req", dmem_req, 1'b0);
    check("rst_dmem_we", dmem_we, 1'b0);
    check("rst_dmem_addr", dmem_addr, 32'h0);
    check("rst_dmem_be", dmem_be, 4'h0);
    check("rst_dmem_wdata", dmem_wdata, 32'h0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_data", resp_data, 32'h0);
    check("rst_resp_wren", resp_wren, 1'b0);
    check("rst_misalign", misalign, 1'b0);
    check("rst_bus_err", bus_err, 1'b0);
    rst = 0;
    chk_en = 1;

    run_txn(mk(ALU_SW, 0, 1, 32'h100, 32'h4, 32'hDEADBEEF, 5'd3, 0, 0, 1, 0, 0, 0));
    check("sw_addr", obs_addr, 32'h104);
    check("sw_be", obs_be, 4'b1111);
    check("sw_wdata", obs_wdata, 32'hDEADBEEF);
    check("sw_we", obs_we, 1'b1);
    check("sw_latency", obs_lat, 2);
    check("sw_wren", obs_wren, 1'b0);

    run_txn(mk(ALU_SB, 0, 1, 32'h100, 32'h3, 32'h000000A5, 5'd1, 0, 0, 1, 0, 0, 0));
    check("sb_be", obs_be, 4'b1000);
    check("sb_wdata", obs_wdata, 32'hA5A5A5A5);

    run_txn(mk(ALU_SH, 0, 1, 32'h100, 32'h2, 32'h00001234, 5'd1, 0, 0, 1, 0, 0, 0));
    check("sh_be", obs_be, 4'b1100);
    check("sh_wdata", obs_wdata, 32'h12341234);

    run_txn(mk(ALU_LB, 1, 0, 32'h100, 32'h2, 0, 5'd9, 32'h00800000, 0, 1, 0, 0, 0));
    check("lb_data", obs_data, 32'hFFFFFF80);
    check("lb_wren", obs_wren, 1'b1);
    check("lb_rd", obs_rd, 5'd9);
    check("lb_latency", obs_lat, 3);

    run_txn(mk(ALU_LBU, 1, 0, 32'h100, 32'h2, 0, 5'd9, 32'h00800000, 0, 1, 0, 0, 0));
    check("lbu_data", obs_data, 32'h00000080);

    run_txn(mk(ALU_LH, 1, 0, 32'h100, 32'h1, 0, 5'd4, 0, 0, 1, 0, 0, 0));
    check("lh_mis_flag", obs_mis, 1'b1);
    check("lh_mis_noreq", 32'(obs_seen_req), 32'd0);
    check("lh_mis_latency", obs_lat, 1);

    run_txn(mk(ALU_LW, 1, 0, 32'h100, 32'h2, 0, 5'd4, 0, 0, 1, 1, 0, 0));
    check("lw_mis_flag", obs_mis, 1'b1);
    check("lw_mis_noreq", 32'(obs_seen_req), 32'd0);
    check("lw_mis_latency", obs_lat, 1);

    run_txn(mk(ALU_LW, 1, 0, 32'h300, 32'h0, 0, 5'd12, 32'hCAFEF00D, 3, 2, 2, 0, 0));
    check("stall_latency", obs_lat, 7);
    check("stall_data", obs_data, 32'hCAFEF00D);

    run_txn(mk(ALU_SW, 0, 1, 32'h400, 32'h0, 32'h11111111, 5'd2, 0, 0, 1, 0, 1, 0));
    check("to_gnt_bus_err", obs_berr, 1'b1);
    check("to_gnt_latency", obs_lat, TO + 1);
    check("to_gnt_req_cycles", obs_req_cycles, TO);

    run_txn(mk(ALU_LW, 1, 0, 32'h400, 32'h0, 0, 5'd2, 0, 0, 1, 0, 0, 1));
    check("to_rv_bus_err", obs_berr, 1'b1);
    check("to_rv_wren", obs_wren, 1'b0);
    check("to_rv_latency", obs_lat, TO + 1);

    run_txn(mk(ALU_LW, 0, 0, 32'h500, 32'h0, 0, 5'd5, 0, 0, 1, 0, 0, 0));
    check("noop_latency", obs_lat, 1);
    check("noop_wren", obs_wren, 1'b0);
    check("noop_noreq", 32'(obs_seen_req), 32'd0);

    reset_in_wait();

    for (int i = 0; i < 300; i++) begin
      txn_t t;
      int   c;
      c = $urandom_range(0, 7);
      t.code = codes[c]; t.ld = (c < 5); t.st = (c >= 5);
      if ($urandom_range(0, 9) == 0) begin t.ld = 0; t.st = 0; end
      t.base = $urandom; t.off = 32'($urandom_range(0, 63)) - 32'd32;
      t.sd = $urandom; t.rdata = $urandom; t.rd = 5'($urandom);
      t.gnt_dly = $urandom_range(0, 3); t.rv_dly = $urandom_range(1, 3);
      t.rdy_dly = $urandom_range(0, 2);
      t.no_gnt = ($urandom_range(0, 19) == 0); t.no_rv = ($urandom_range(0, 19) == 0);
      run_txn(t);
      if ($urandom_range(0, 3) == 0) idle_gap($urandom_range(1, 3));
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
